l1_line_bridge: RTL and testbench

Parametrised bridge between the L1 cache line port and the backing memory and MMIO buses. It serialises one LINE_WIDTH cache line into LINE_WIDTH/MEM_WIDTH beats over a variable-latency req/ack memory port, and diverts MMIO-range addresses to a 32-bit MMIO port with a timeout. It sits between the L1 cache controller and the memory controller / MMIO fabric, and is the successor of the fixed two-beat 256/128 bridge.

---
 rtl/l1_line_bridge.sv | 163 ++++++++++++++++
 tb/tb_l1_line_bridge.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_line_bridge.sv
// L1 line bridge: splits one cache line into memory beats over a req/ack port, and sends
// MMIO-range addresses to a 32-bit MMIO port that gives up after a fixed number of cycles.
module l1_line_bridge #(
  parameter int unsigned           LINE_WIDTH   = 256,
  parameter int unsigned           MEM_WIDTH    = 128,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] MMIO_MASK    = 32'hFFFF_0000,
  parameter logic [ADDR_WIDTH-1:0] MMIO_MATCH   = 32'hFFFF_0000,
  parameter int unsigned           MMIO_TIMEOUT = 255
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  l1_req_read,
  input  logic                  l1_req_write,
  input  logic [ADDR_WIDTH-1:0] l1_req_addr,
  input  logic [LINE_WIDTH-1:0] l1_write_data,
  output logic                  l1_read_done,
  output logic                  l1_write_done,
  output logic                  l1_error,
  output logic [LINE_WIDTH-1:0] l1_read_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_ack,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  output logic                  mmio_read,
  output logic                  mmio_write,
  output logic [31:0]           mmio_addr,
  output logic [31:0]           mmio_write_data,
  input  logic                  mmio_done,
  input  logic [31:0]           mmio_read_data
);

  localparam int unsigned BEATS = LINE_WIDTH / MEM_WIDTH;
  localparam int unsigned OFF   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BIDX  = $clog2(BEATS);
  localparam int unsigned BIW   = (BIDX > 0) ? BIDX : 1;
  localparam int unsigned LW    = $clog2(LINE_WIDTH);

  localparam logic [BIW-1:0] LastBeat   = BIW'(BEATS - 1);
  localparam logic [7:0]     TimeoutCnt = 8'(MMIO_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StMem, StMmio, StDone, StRelease} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [BIW-1:0]        beat_q, beat_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rd_done_q, rd_done_d;
  logic                  wr_done_q, wr_done_d;
  logic                  error_q, error_d;

  logic                  is_mmio;
  logic [LW-1:0]         beat_base;
  logic [ADDR_WIDTH-1:0] line_addr;

  assign is_mmio   = (l1_req_addr & MMIO_MASK) == MMIO_MATCH;
  assign beat_base = LW'(beat_q * MEM_WIDTH);
  assign line_addr = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (l1_req_read || l1_req_write) begin
          we_d    = ~l1_req_read;
          addr_d  = l1_req_addr;
          line_d  = l1_write_data;
          beat_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = is_mmio ? StMmio : StMem;
        end
      end
      StMem: begin
        if (mem_ack) begin
          if (!we_q) rdata_d[beat_base +: MEM_WIDTH] = mem_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) state_d = StDone;
        end
      end
      StMmio: begin
        // A late mmio_done in the timeout cycle still wins over the error.
        if (mmio_done) begin
          if (!we_q) rdata_d = LINE_WIDTH'(mmio_read_data);
          state_d = StDone;
        end else if (cnt_q == TimeoutCnt) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: state_d = StRelease;
      StRelease: begin
        if (!l1_req_read && !l1_req_write) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Completion flops line up exactly with the single DONE cycle.
    rd_done_d = (state_d == StDone) && !we_d;
    wr_done_d = (state_d == StDone) && we_d;
    error_d   = (state_d == StDone) && err_d;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      line_q    <= '0;
      rdata_q   <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      rdata_q   <= rdata_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      error_q   <= error_d;
    end
  end

  assign l1_read_done    = rd_done_q;
  assign l1_write_done   = wr_done_q;
  assign l1_error        = error_q;
  assign l1_read_data    = rdata_q;

  assign mem_req         = (state_q == StMem);
  assign mem_we          = (state_q == StMem) && we_q;
  assign mem_addr        = line_addr | ADDR_WIDTH'(beat_q * (MEM_WIDTH / 8));
  assign mem_wdata       = line_q[beat_base +: MEM_WIDTH];

  assign mmio_read       = (state_q == StMmio) && !we_q;
  assign mmio_write      = (state_q == StMmio) && we_q;
  assign mmio_addr       = 32'(addr_q) & 32'hFFFF_FFFC;
  assign mmio_write_data = line_q[31:0];

endmodule

// File: tb/tb_l1_line_bridge.sv
// Scoreboard bench for l1_line_bridge: instance A uses 256/128 with a short MMIO timeout,
// instance B uses 256/32 for the narrow-beat write.
module tb_l1_line_bridge;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int pcyc = 0;
  always @(posedge sys_clk) pcyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]  addr;
    bit           we;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } beat_t;

  typedef struct {
    int           cyc;
    bit           we;
    bit           err;
    logic [255:0] line;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } io_t;

  beat_t a_beat_q[$];
  beat_t b_beat_q[$];
  done_t a_done_q[$];
  done_t b_done_q[$];
  io_t   a_io_q[$];

  int a_wait = 0;
  int b_wait = 0;

  // Instance A signals
  logic         a_rd = 0, a_wr = 0;
  logic [31:0]  a_addr = '0;
  logic [255:0] a_wline = '0;
  logic         a_rdone, a_wdone, a_err;
  logic [255:0] a_rline;
  logic         a_mreq, a_mwe;
  logic [31:0]  a_maddr;
  logic [127:0] a_mwdata;
  logic         a_mack = 0;
  logic [127:0] a_mrdata = '0;
  logic         a_ioread, a_iowrite;
  logic [31:0]  a_ioaddr, a_iowdata;
  logic         a_iodone = 0;
  logic [31:0]  a_iordata = '0;

  // Instance B signals
  logic         b_rd = 0, b_wr = 0;
  logic [31:0]  b_addr = '0;
  logic [255:0] b_wline = '0;
  logic         b_rdone, b_wdone, b_err;
  logic [255:0] b_rline;
  logic         b_mreq, b_mwe;
  logic [31:0]  b_maddr;
  logic [31:0]  b_mwdata;
  logic         b_mack = 0;
  logic [31:0]  b_mrdata = '0;
  logic         b_ioread, b_iowrite;
  logic [31:0]  b_ioaddr, b_iowdata;
  logic         b_iodone = 0;
  logic [31:0]  b_iordata = '0;

  l1_line_bridge #(
    .LINE_WIDTH(256), .MEM_WIDTH(128), .ADDR_WIDTH(32),
    .MMIO_MASK(32'hFFFF_0000), .MMIO_MATCH(32'hFFFF_0000), .MMIO_TIMEOUT(10)
  ) u_dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .l1_req_read(a_rd), .l1_req_write(a_wr), .l1_req_addr(a_addr), .l1_write_data(a_wline),
    .l1_read_done(a_rdone), .l1_write_done(a_wdone), .l1_error(a_err), .l1_read_data(a_rline),
    .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_ack(a_mack), .mem_rdata(a_mrdata),
    .mmio_read(a_ioread), .mmio_write(a_iowrite), .mmio_addr(a_ioaddr),
    .mmio_write_data(a_iowdata), .mmio_done(a_iodone), .mmio_read_data(a_iordata)
  );

  l1_line_bridge #(
    .LINE_WIDTH(256), .MEM_WIDTH(32), .ADDR_WIDTH(32),
    .MMIO_MASK(32'hFFFF_0000), .MMIO_MATCH(32'hFFFF_0000), .MMIO_TIMEOUT(255)
  ) u_dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .l1_req_read(b_rd), .l1_req_write(b_wr), .l1_req_addr(b_addr), .l1_write_data(b_wline),
    .l1_read_done(b_rdone), .l1_write_done(b_wdone), .l1_error(b_err), .l1_read_data(b_rline),
    .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_ack(b_mack), .mem_rdata(b_mrdata),
    .mmio_read(b_ioread), .mmio_write(b_iowrite), .mmio_addr(b_ioaddr),
    .mmio_write_data(b_iowdata), .mmio_done(b_iodone), .mmio_read_data(b_iordata)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(logic [31:0] addr, bit we, logic [127:0] wdata,
                                    logic [127:0] rdata);
    beat_t b;
    b.addr  = addr;
    b.we    = we;
    b.wdata = wdata;
    b.rdata = rdata;
    return b;
  endfunction

  function automatic io_t mk_io(logic [31:0] addr, bit we, logic [31:0] wdata, int delay,
                                logic [31:0] rdata);
    io_t e;
    e.addr  = addr;
    e.we    = we;
    e.wdata = wdata;
    e.delay = delay;
    e.rdata = rdata;
    return e;
  endfunction

  task automatic check_a_zero(input string tag);
    check({tag, "_a_ctl"}, {a_rdone, a_wdone, a_err, a_mreq, a_mwe, a_ioread, a_iowrite}, '0);
    check({tag, "_a_bus"}, {a_maddr, a_mwdata, a_ioaddr, a_iowdata}, '0);
    check({tag, "_a_rline"}, a_rline, '0);
  endtask

  task automatic check_b_zero(input string tag);
    check({tag, "_b_ctl"}, {b_rdone, b_wdone, b_err, b_mreq, b_mwe, b_ioread, b_iowrite}, '0);
    check({tag, "_b_bus"}, {b_maddr, b_mwdata, b_ioaddr, b_iowdata, b_rline}, '0);
  endtask

  // Called on a negedge: drives the level request and books the expected completion.
  task automatic a_start(input bit we, input logic [31:0] addr, input logic [255:0] wl,
                         input int done_after, input bit err, input logic [255:0] line);
    done_t d;
    d.cyc  = pcyc + done_after;
    d.we   = we;
    d.err  = err;
    d.line = line;
    a_done_q.push_back(d);
    a_addr  = addr;
    a_wline = wl;
    a_rd    = !we;
    a_wr    = we;
  endtask

  task automatic a_finish(input int hold);
    for (int i = 0; i < 300 && a_done_q.size() != 0; i++) @(negedge sys_clk);
    check("a_done_pending", a_done_q.size(), 0);
    a_done_q.delete();
    repeat (hold) @(negedge sys_clk);
    a_rd = 0;
    a_wr = 0;
    repeat (2) @(negedge sys_clk);
  endtask

  // Memory models: ack after a_wait/b_wait idle cycles of each beat, check the beat on ack.
  always @(negedge sys_clk) begin : a_mem_model
    int    wcnt;
    beat_t bt;
    if (!rst_n || !a_mreq) begin
      a_mack = 0;
      wcnt   = 0;
    end else if (wcnt >= a_wait) begin
      a_mack = 1;
      wcnt   = 0;
      if (a_beat_q.size() == 0) begin
        check("a_mem_unexpected", 1, 0);
      end else begin
        bt = a_beat_q.pop_front();
        check("a_mem_addr", a_maddr, bt.addr);
        check("a_mem_we", a_mwe, bt.we);
        if (bt.we) check("a_mem_wdata", a_mwdata, bt.wdata);
        a_mrdata = bt.rdata;
      end
    end else begin
      a_mack = 0;
      wcnt++;
    end
  end

  always @(negedge sys_clk) begin : b_mem_model
    int    wcnt;
    beat_t bt;
    if (!rst_n || !b_mreq) begin
      b_mack = 0;
      wcnt   = 0;
    end else if (wcnt >= b_wait) begin
      b_mack = 1;
      wcnt   = 0;
      if (b_beat_q.size() == 0) begin
        check("b_mem_unexpected", 1, 0);
      end else begin
        bt = b_beat_q.pop_front();
        check("b_mem_addr", b_maddr, bt.addr);
        check("b_mem_we", b_mwe, bt.we);
        check("b_mem_wdata", b_mwdata, bt.wdata);
        b_mrdata = bt.rdata[31:0];
      end
    end else begin
      b_mack = 0;
      wcnt++;
    end
  end

  // MMIO model for A: checks the strobe on its first cycle, answers after 'delay' cycles.
  always @(negedge sys_clk) begin : a_io_model
    int   cnt;
    io_t  e;
    if (!rst_n || !(a_ioread || a_iowrite)) begin
      cnt      = 0;
      a_iodone = 0;
    end else begin
      if (cnt == 0) begin
        if (a_io_q.size() == 0) begin
          check("a_io_unexpected", 1, 0);
          e.delay = -1;
        end else begin
          e = a_io_q.pop_front();
          check("a_io_addr", a_ioaddr, e.addr);
          check("a_io_strobe", {a_ioread, a_iowrite}, {!e.we, e.we});
          if (e.we) check("a_io_wdata", a_iowdata, e.wdata);
        end
      end
      if (e.delay >= 0 && cnt == e.delay) begin
        a_iodone  = 1;
        a_iordata = e.rdata;
      end else begin
        a_iodone = 0;
      end
      cnt++;
    end
  end

  // Completion monitors: every done pulse must match one booked completion.
  always @(negedge sys_clk) begin : a_done_mon
    done_t d;
    if (rst_n && (a_rdone || a_wdone || a_err)) begin
      if (a_done_q.size() == 0) begin
        check("a_done_unexpected", 1, 0);
      end else begin
        d = a_done_q.pop_front();
        check("a_done_cycle", pcyc, d.cyc);
        check("a_done_kind", {a_rdone, a_wdone, a_err}, {!d.we, d.we, d.err});
        check("a_read_data", a_rline, d.line);
        check("a_strobes_at_done", {a_mreq, a_ioread, a_iowrite}, '0);
      end
    end
  end

  always @(negedge sys_clk) begin : b_done_mon
    done_t d;
    if (rst_n && (b_rdone || b_wdone || b_err)) begin
      if (b_done_q.size() == 0) begin
        check("b_done_unexpected", 1, 0);
      end else begin
        d = b_done_q.pop_front();
        check("b_done_cycle", pcyc, d.cyc);
        check("b_done_kind", {b_rdone, b_wdone, b_err}, {!d.we, d.we, d.err});
        check("b_read_data", b_rline, d.line);
      end
    end
  end

  initial begin
    logic [255:0] line;
    done_t        d;

    repeat (3) @(negedge sys_clk);
    check_a_zero("reset");
    check_b_zero("reset");
    rst_n = 1;
    repeat (2) @(negedge sys_clk);

    // Zero-wait read on A.
    a_wait = 0;
    a_beat_q.push_back(mk_beat(32'h0000_1040, 0, '0, {32{4'hA}}));
    a_beat_q.push_back(mk_beat(32'h0000_1050, 0, '0, {32{4'hB}}));
    a_start(0, 32'h0000_1040, '0, 3, 0, {{32{4'hB}}, {32{4'hA}}});
    a_finish(0);

    // Narrow-beat write on B: ack in the second cycle of each beat.
    b_wait = 1;
    for (int k = 0; k < 8; k++) begin
      line[32*k +: 32] = 32'hC0DE_0000 + 32'(k) * 32'h0101_1111;
      b_beat_q.push_back(mk_beat(32'h2000 + 32'(4 * k), 1, 128'(line[32*k +: 32]), '0));
    end
    d.cyc  = pcyc + 17;
    d.we   = 1;
    d.err  = 0;
    d.line = '0;
    b_done_q.push_back(d);
    b_addr  = 32'h0000_2000;
    b_wline = line;
    b_wr    = 1;
    for (int i = 0; i < 300 && b_done_q.size() != 0; i++) @(negedge sys_clk);
    check("b_done_pending", b_done_q.size(), 0);
    b_done_q.delete();
    b_wr = 0;
    repeat (3) @(negedge sys_clk);

    // MMIO read answered after three strobe cycles.
    a_io_q.push_back(mk_io(32'hFFFF_0004, 0, '0, 3, 32'h1234_5678));
    a_start(0, 32'hFFFF_0006, '0, 5, 0, 256'h1234_5678);
    a_finish(0);

    // MMIO write that is never answered: timeout after 10 counted cycles.
    a_io_q.push_back(mk_io(32'hFFFF_0010, 1, 32'hDEAD_BEEF, -1, '0));
    a_start(1, 32'hFFFF_0010, {8{32'hDEAD_BEEF}}, 12, 1, '0);
    a_finish(0);

    // Request held 5 cycles past done must complete exactly once.
    a_beat_q.push_back(mk_beat(32'h0000_3000, 0, '0, {32{4'hC}}));
    a_beat_q.push_back(mk_beat(32'h0000_3010, 0, '0, {32{4'hD}}));
    a_start(0, 32'h0000_3000, '0, 3, 0, {{32{4'hD}}, {32{4'hC}}});
    a_finish(5);

    // Slow read aborted by reset during its second beat.
    a_wait = 3;
    a_beat_q.push_back(mk_beat(32'h0000_4000, 0, '0, {32{4'hE}}));
    a_addr  = 32'h0000_4000;
    a_wline = {8{32'h5A5A_A5A5}};
    a_rd    = 1;
    repeat (6) @(posedge sys_clk);
    #2 rst_n = 0;
    #1;
    check_a_zero("async_reset");
    check("beat0_consumed", a_beat_q.size(), 0);
    a_rd = 0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n  = 1;
    a_wait = 0;
    repeat (2) @(negedge sys_clk);
    check("post_reset_idle", {a_mreq, a_ioread, a_iowrite, a_rdone, a_wdone}, '0);

    // Bridge accepts again after reset; unaligned address maps to its line.
    a_beat_q.push_back(mk_beat(32'h0000_0040, 0, '0, {32{4'h1}}));
    a_beat_q.push_back(mk_beat(32'h0000_0050, 0, '0, {32{4'h2}}));
    a_start(0, 32'h0000_0050, '0, 3, 0, {{32{4'h2}}, {32{4'h1}}});
    a_finish(0);

    check("leftover_items",
          a_beat_q.size() + b_beat_q.size() + a_io_q.size() + a_done_q.size() + b_done_q.size(),
          0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
